// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU function codes and arbiter FSM state constants shared by the arbiter and its ALU.
package alu_arbiter_pkg;
    localparam logic [2:0] ALU_INC    = 3'd0;
    localparam logic [2:0] ALU_ADD_FA = 3'd1;
    localparam logic [2:0] ALU_ADD    = 3'd2;
    localparam logic [2:0] ALU_XOR_OR = 3'd3;
    localparam logic [2:0] ALU_ANY    = 3'd4;
    localparam logic [2:0] ALU_CONCAT = 3'd5;
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_EXEC   = 2'd1;
    localparam logic [1:0] ARB_DONE   = 2'd2;
    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: 4-bit combinational ALU built on a ripple adder of mux-based full adders.
module mux2to1 (
    input  logic x,
    input  logic y,
    input  logic s,
    output logic m
);
    assign m = s ? y : x;
endmodule

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    assign p = a ^ b;
    assign s = p ^ ci;
    // propagate passes the incoming carry, otherwise both bits agree and b is the carry
    mux2to1 u_mux (.x(b), .y(ci), .s(p), .m(co));
endmodule

module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;
    assign c[0] = ci;
    assign co   = c[4];
    for (genvar i = 0; i < 4; i++) begin : g_fa
        fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
endmodule

module alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] func,
    output logic [7:0] out
);
    logic [3:0] sum;
    logic       co;
    logic [3:0] addend;
    assign addend = func == ALU_INC ? 4'd1 : b;
    four_bit_adder u_add (.a(a), .b(addend), .ci(1'b0), .s(sum), .co(co));
    assign out = func == ALU_INC || func == ALU_ADD_FA ? {co, 3'b000, sum} :
                 func == ALU_ADD    ? {4'b0000, sum} :
                 func == ALU_XOR_OR ? {a | b, a ^ b} :
                 func == ALU_ANY    ? {7'd0, |(a | b)} :
                 func == ALU_CONCAT ? {a, b} : 8'h00;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters through a 3-state capture/execute/done FSM.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [2:0] func0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [2:0] func1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] result,
    output logic       busy
);
    logic [1:0] state;
    logic [2:0] op_func;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       owner;
    logic       win;
    logic [7:0] alu_out;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    logic last;
    assign win = &req ? ~last : req[1];
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) last <= 1'b1;
        else if (state == ARB_IDLE && |req) last <= win;
`endif

    assign busy = state != ARB_IDLE;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= ARB_IDLE;
            gnt     <= 2'b00;
            done    <= 2'b00;
            result  <= 8'h00;
            op_func <= 3'd0;
            op_a    <= 4'd0;
            op_b    <= 4'd0;
            owner   <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (|req) begin
                op_func <= win ? func1 : func0;
                op_a    <= win ? a1 : a0;
                op_b    <= win ? b1 : b0;
                owner   <= win;
                gnt     <= onehot(win);
                state   <= ARB_EXEC;
            end
        end else if (state == ARB_EXEC) begin
            result <= alu_out;
            done   <= onehot(owner);
            gnt    <= 2'b00;
            state  <= ARB_DONE;
        end else begin
            done  <= 2'b00;
            state <= ARB_IDLE;
        end
    end

    alu u_alu (.a(op_a), .b(op_b), .func(op_func), .out(alu_out));
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter against a transaction-level model.
// Define ALU_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_alu_arbiter;
    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic [1:0] req = 2'b00;
    logic [2:0] func0 = 3'd0, func1 = 3'd0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
    logic [1:0] gnt, done;
    logic [7:0] result;
    logic       busy;
    int tests = 0;
    int fails = 0;
    int last_w = 1;

    always #5 clock = ~clock;

    alu_arbiter dut (
        .clock(clock), .resetn(resetn), .req(req),
        .func0(func0), .a0(a0), .b0(b0),
        .func1(func1), .a1(a1), .b1(b1),
        .gnt(gnt), .done(done), .result(result), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        int s;
        s = int'(a) + ((f == 3'd0) ? 1 : int'(b));
        case (f)
            3'd0, 3'd1: return {s > 15, 3'b000, 4'(s)};
            3'd2:       return {4'b0000, 4'(s)};
            3'd3:       return {a | b, a ^ b};
            3'd4:       return (a | b) != 4'd0 ? 8'd1 : 8'd0;
            3'd5:       return {a, b};
            default:    return 8'h00;
        endcase
    endfunction

    task automatic pick(input logic [1:0] r, output int w);
        if (r == 2'b01) w = 0;
        else if (r == 2'b10) w = 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        else w = 0;
`else
        else w = (last_w == 1) ? 0 : 1;
`endif
        last_w = w;
    endtask

    task automatic apply_reset();
        req = 2'b00;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        last_w = 1;
        @(negedge clock);
    endtask

    // Issues one command from IDLE and samples outputs in the grant, done and return-to-idle cycles.
    task automatic run_cmd(input logic [1:0] r, input logic [2:0] f0, input logic [3:0] x0, input logic [3:0] y0,
                           input logic [2:0] f1, input logic [3:0] x1, input logic [3:0] y1,
                           output logic [1:0] g, output logic [1:0] d, output logic [1:0] d3,
                           output logic [7:0] res, output logic [2:0] bz);
        req = r; func0 = f0; a0 = x0; b0 = y0; func1 = f1; a1 = x1; b1 = y1;
        @(negedge clock);
        g = gnt; bz[2] = busy;
        req = 2'b00;
        func0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
        func1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        @(negedge clock);
        d = done; res = result; bz[1] = busy;
        @(negedge clock);
        d3 = done; bz[0] = busy;
    endtask

    task automatic test_reset();
        #3 resetn = 1'b0;
        #1;
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        tests++; if (done !== 2'b00) begin fails++; $display("FAIL reset_done: got %b want 00", done); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result: got %h want 00", result); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        last_w = 1;
        @(negedge clock);
    endtask

    task automatic test_single();
        logic [1:0] g, d, d3;
        logic [7:0] res;
        logic [2:0] bz;
        int w;
        apply_reset();
        pick(2'b01, w);
        run_cmd(2'b01, 3'd1, 4'hF, 4'h1, 3'd0, 4'h0, 4'h0, g, d, d3, res, bz);
        tests++; if (g !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b want 01", g); end
        tests++; if (d !== 2'b01) begin fails++; $display("FAIL single_done: got %b want 01", d); end
        tests++; if (res !== 8'h80) begin fails++; $display("FAIL single_result: got %h want 80", res); end
        tests++; if (bz !== 3'b110) begin fails++; $display("FAIL single_busy: got %b want 110", bz); end
        tests++; if (d3 !== 2'b00) begin fails++; $display("FAIL single_done_clear: got %b want 00", d3); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q_res[$];
        logic [1:0] q_own[$];
        logic [1:0] exp_g;
        logic [1:0] exp_d;
        logic [7:0] exp_r;
        int w;
        apply_reset();
        func0 = 3'd3; a0 = 4'h5; b0 = 4'h3;
        func1 = 3'd5; a1 = 4'hA; b1 = 4'hC;
        req = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            exp_g = 2'b00;
            if ((k - 1) % 3 == 0) begin
                pick(2'b11, w);
                exp_g = w == 1 ? 2'b10 : 2'b01;
                q_own.push_back(exp_g);
                q_res.push_back(w == 1 ? alu_ref(func1, a1, b1) : alu_ref(func0, a0, b0));
            end
            tests++; if (gnt !== exp_g) begin fails++; $display("FAIL b2b_gnt k=%0d: got %b want %b", k, gnt, exp_g); end
            if ((k - 2) % 3 == 0) begin
                exp_d = q_own.pop_front();
                exp_r = q_res.pop_front();
                tests++; if (done !== exp_d) begin fails++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done, exp_d); end
                tests++; if (result !== exp_r) begin fails++; $display("FAIL b2b_result k=%0d: got %h want %h", k, result, exp_r); end
            end
        end
        req = 2'b00;
        @(negedge clock);
    endtask

    task automatic test_any();
        logic [1:0] g, d, d3;
        logic [7:0] res;
        logic [2:0] bz;
        logic [2:0] fs[3] = '{3'd4, 3'd4, 3'd7};
        logic [3:0] bs[3] = '{4'h0, 4'h8, 4'h8};
        logic [7:0] want[3] = '{8'h00, 8'h01, 8'h00};
        int w;
        for (int i = 0; i < 3; i++) begin
            pick(2'b10, w);
            run_cmd(2'b10, 3'd2, 4'h7, 4'h7, fs[i], 4'h0, bs[i], g, d, d3, res, bz);
            tests++; if (g !== 2'b10) begin fails++; $display("FAIL any_gnt %0d: got %b want 10", i, g); end
            tests++; if (d !== 2'b10) begin fails++; $display("FAIL any_done %0d: got %b want 10", i, d); end
            tests++; if (res !== want[i]) begin fails++; $display("FAIL any_result %0d: got %h want %h", i, res, want[i]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] g, d, d3, r, exp_g;
        logic [7:0] res, exp_r;
        logic [2:0] bz, f0, f1;
        logic [3:0] x0, y0, x1, y1;
        int w;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                tests++; if (gnt !== 2'b00 || busy !== 1'b0) begin fails++; $display("FAIL rand_idle %0d: got gnt=%b busy=%b want 00/0", n, gnt, busy); end
            end
            r = 2'($urandom_range(1, 3));
            f0 = 3'($urandom); x0 = 4'($urandom); y0 = 4'($urandom);
            f1 = 3'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
            pick(r, w);
            exp_g = w == 1 ? 2'b10 : 2'b01;
            exp_r = w == 1 ? alu_ref(f1, x1, y1) : alu_ref(f0, x0, y0);
            run_cmd(r, f0, x0, y0, f1, x1, y1, g, d, d3, res, bz);
            tests++; if (g !== exp_g) begin fails++; $display("FAIL rand_gnt %0d: got %b want %b", n, g, exp_g); end
            tests++; if (d !== exp_g) begin fails++; $display("FAIL rand_done %0d: got %b want %b", n, d, exp_g); end
            tests++; if (res !== exp_r) begin fails++; $display("FAIL rand_result %0d: got %h want %h", n, res, exp_r); end
            tests++; if (bz !== 3'b110 || d3 !== 2'b00) begin fails++; $display("FAIL rand_timing %0d: got busy=%b done=%b want 110/00", n, bz, d3); end
        end
    endtask

    task automatic test_reset_midexec();
        int pulses = 0;
        int busy_seen = 0;
        req = 2'b01; func0 = 3'd0; a0 = 4'hF; b0 = 4'h0;
        @(negedge clock);
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL midexec_gnt: got %b want 01", gnt); end
        req = 2'b00;
        #2 resetn = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midexec_busy: got %b want 0", busy); end
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL midexec_gnt_clr: got %b want 00", gnt); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL midexec_result: got %h want 00", result); end
        repeat (2) begin
            @(negedge clock);
            if (done !== 2'b00) pulses++;
        end
        resetn = 1'b1;
        last_w = 1;
        repeat (4) begin
            @(negedge clock);
            if (done !== 2'b00) pulses++;
            if (busy !== 1'b0) busy_seen++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL midexec_done_pulses: got %0d want 0", pulses); end
        tests++; if (busy_seen !== 0) begin fails++; $display("FAIL midexec_idle_busy: got %0d want 0", busy_seen); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL midexec_result_hold: got %h want 00", result); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_any();
        test_random();
        test_reset_midexec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
